// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if: CPU-side load/store bus of the data memory.
// master = CPU/encoder side, slave = memory controller.
interface data_mem_ctrl_if;
  logic        memRead;
  logic        memWrite;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [3:0]  memEnable;
  logic [31:0] readData;
  logic        stall;
  logic        accessErr;

  modport master (
    output memRead,
    output memWrite,
    output address,
    output writeData,
    output memEnable,
    input  readData,
    input  stall,
    input  accessErr
  );

  modport slave (
    input  memRead,
    input  memWrite,
    input  address,
    input  writeData,
    input  memEnable,
    output readData,
    output stall,
    output accessErr
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-lane data memory behind a wait-state
// access FSM that stalls the CPU until each access completes.
module data_mem_ctrl #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 2
) (
  input logic           clk,
  input logic           rst,
  data_mem_ctrl_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW =
    (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  typedef struct packed {
    logic                  wr;
    logic                  rd;
    logic                  oor;
    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0]           wd;
    logic [3:0]            en;
  } req_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  req_t          req_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic          req, take, fire, stall;
  logic          unused_ok;

  logic [31:0] mem [DEPTH];

  assign req = bus.memRead | bus.memWrite;
  assign unused_ok = ^bus.address[1:0];

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    take    = 1'b0;
    fire    = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall = req;
        if (req) begin
          take    = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt_q == '0) begin
          fire    = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= 1'b0;
      if (take) begin
        cnt_q     <= CW'(WAIT_STATES);
        req_q.wr  <= bus.memWrite;
        req_q.rd  <= bus.memRead & ~bus.memWrite;
        req_q.oor <= |bus.address[31:ADDR_WIDTH+2];
        req_q.idx <= bus.address[ADDR_WIDTH+1:2];
        req_q.wd  <= bus.writeData;
        req_q.en  <= bus.memEnable;
      end else if (state_q == BUSY && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (fire) begin
        err_q <= req_q.oor |
                 (req_q.wr & (req_q.en == 4'b0000));
        if (req_q.rd)
          rdata_q <= req_q.oor ? 32'h0 : mem[req_q.idx];
      end
    end
  end

  // Array has no reset; rst only suppresses a store on its edge.
  always_ff @(posedge clk) begin
    if (fire && req_q.wr && !req_q.oor && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (req_q.en[i])
          mem[req_q.idx][31-8*i -: 8] <= req_q.wd[31-8*i -: 8];
      end
    end
  end

  assign bus.stall     = stall;
  assign bus.readData  = rdata_q;
  assign bus.accessErr = err_q;

endmodule
